// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divide sequencer handshake: operation request, pipeline stall and result.
interface div_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, operand_a_i, operand_b_i, flush_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, operand_a_i, operand_b_i, flush_i,
        output busy_o, stall_o, done_o, result_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide on magnitudes,
// sign fix-up registered on the last iteration, one-cycle done pulse.
module div_seq_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    div_seq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              is_rem_q, is_rem_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;
    logic              accept;

    always_comb begin
        is_signed = ~bus.op_i[0];
        a_neg     = is_signed & bus.operand_a_i[XLEN-1];
        b_neg     = is_signed & bus.operand_b_i[XLEN-1];
        abs_a     = a_neg ? (~bus.operand_a_i + 1'b1) : bus.operand_a_i;
        abs_b     = b_neg ? (~bus.operand_b_i + 1'b1) : bus.operand_b_i;
        accept    = (state_q == IDLE) & bus.start_i & ~bus.flush_i;

        // {rem,quo} shifted left by one; the XLEN+1 bit subtract keeps the carried-out rem MSB
        trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        rem_nx = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ~trial[XLEN]};
        q_fix  = (sa_q ^ sb_q) ? (~quo_nx + 1'b1) : quo_nx;
        r_fix  = sa_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d = bus.op_i[1];
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    dvs_d    = abs_b;
                    if (bus.operand_b_i == '0) begin
                        state_d  = DONE;
                        result_d = bus.op_i[1] ? bus.operand_a_i : '1;
                    end else if (is_signed && bus.operand_a_i == {1'b1, {(XLEN-1){1'b0}}}
                                 && bus.operand_b_i == '1) begin
                        state_d  = DONE;
                        result_d = bus.op_i[1] ? '0 : bus.operand_a_i;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN);
                        rem_d   = '0;
                        quo_d   = abs_a;
                    end
                end
            end
            CALC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        result_d = is_rem_q ? r_fix : q_fix;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    // rst_n gates the combinational accept term so a held start_i cannot stall during reset
    assign bus.busy_o   = (state_q == CALC);
    assign bus.stall_o  = rst_n & (accept | (state_q == CALC));
    assign bus.done_o   = (state_q == DONE) & ~bus.flush_i;
    assign bus.result_o = result_q;

endmodule
